// File: rtl/sreg_load_sequencer_pkg.sv
// Shared encodings and default sizes for the config shift-register load sequencer.
package sreg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  typedef enum logic {
    SRC_STAT = 1'b0,
    SRC_DYN  = 1'b1
  } src_t;

  localparam int unsigned DEF_SIZESRSTAT   = 88;
  localparam int unsigned DEF_SIZESRDYN    = 16;
  localparam int unsigned DEF_SETUP_CYCLES = 8;
  localparam int unsigned DEF_HOLD_CYCLES  = 4;
  localparam int unsigned DEF_CNT_W        = 7;

endpackage

// File: rtl/sreg_load_sequencer_if.sv
// Requester handshakes and serial shift-register chain signals of the load sequencer.
interface sreg_load_sequencer_if #(
  parameter int unsigned SIZESRSTAT = 88,
  parameter int unsigned SIZESRDYN  = 16
);
  logic                  stat_req;
  logic [SIZESRSTAT-1:0] stat_data;
  logic                  stat_ack;
  logic                  dyn_req;
  logic [SIZESRDYN-1:0]  dyn_data;
  logic                  dyn_ack;
  logic                  sel_stat;
  logic                  sel_dyn;
  logic                  sdata;
  logic                  latch;
  logic                  done;
  logic                  busy;
  logic                  en_fin;

  modport slave (
    input  stat_req, stat_data, dyn_req, dyn_data,
    output stat_ack, dyn_ack, sel_stat, sel_dyn, sdata, latch, done, busy, en_fin
  );

  modport master (
    output stat_req, stat_data, dyn_req, dyn_data,
    input  stat_ack, dyn_ack, sel_stat, sel_dyn, sdata, latch, done, busy, en_fin
  );
endinterface

// File: rtl/sreg_load_sequencer_piso.sv
// Parallel-load shadow register with MSB-first registered serial output and bit down-counter.
module sreg_piso #(
  parameter int unsigned SIZESRSTAT = 88,
  parameter int unsigned CNT_W      = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [SIZESRSTAT-1:0] pdata,
  input  logic [CNT_W-1:0]      len,
  output logic                  sdata,
  output logic                  last
);
  logic [SIZESRSTAT-1:0] shadow_q;
  logic [CNT_W-1:0]      cnt_q;

  // shift_en is asserted on the edge that enters each shift cycle, so the counter
  // reads N-1 during the first bit and 0 during the final bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      sdata    <= 1'b0;
    end else if (load) begin
      shadow_q <= pdata;
      cnt_q    <= len;
      sdata    <= 1'b0;
    end else if (shift_en) begin
      sdata    <= shadow_q[SIZESRSTAT-1];
      shadow_q <= {shadow_q[SIZESRSTAT-2:0], 1'b0};
      cnt_q    <= cnt_q - CNT_W'(1);
    end else begin
      sdata    <= 1'b0;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/sreg_load_sequencer.sv
// Arbitrates static/dynamic config loads and serialises the granted word onto the shift chain.
module sreg_load_sequencer
  import sreg_ctrl_pkg::*;
#(
  parameter int unsigned SIZESRSTAT   = DEF_SIZESRSTAT,
  parameter int unsigned SIZESRDYN    = DEF_SIZESRDYN,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  sreg_load_sequencer_if.slave  bus
);
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  src_t                  src_q, src_d;
  src_t                  last_grant_q, last_grant_d;
  src_t                  grant_src;
  logic                  grant;
  logic                  done_d;
  logic [SIZESRSTAT-1:0] pdata;
  logic [CNT_W-1:0]      len;
  logic                  shift_en;
  logic                  last;
  logic                  stat_ack_q, dyn_ack_q, sel_stat_q, sel_dyn_q;
  logic                  latch_q, done_q, busy_q, en_fin_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    grant        = 1'b0;
    grant_src    = SRC_STAT;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.stat_req || bus.dyn_req) begin
          grant = 1'b1;
          if (bus.stat_req && bus.dyn_req)
            grant_src = (last_grant_q == SRC_DYN) ? SRC_STAT : SRC_DYN;
          else
            grant_src = bus.stat_req ? SRC_STAT : SRC_DYN;
          src_d        = grant_src;
          last_grant_d = grant_src;
          state_d      = ST_SETUP;
          // SETUP counts SETUP_CYCLES down to 0, so the ack cycle plus SETUP_CYCLES idle cycles precede bit 1.
          cnt_d        = CNT_W'(SETUP_CYCLES);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) state_d = ST_SHIFT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SHIFT: begin
        if (last) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_HOLD;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pdata    = (grant_src == SRC_DYN) ? (SIZESRSTAT'(bus.dyn_data) << (SIZESRSTAT - SIZESRDYN))
                                           : bus.stat_data;
  assign len      = (grant_src == SRC_DYN) ? CNT_W'(SIZESRDYN) : CNT_W'(SIZESRSTAT);
  assign shift_en = (state_d == ST_SHIFT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      src_q        <= SRC_STAT;
      last_grant_q <= SRC_DYN;
      stat_ack_q   <= 1'b0;
      dyn_ack_q    <= 1'b0;
      sel_stat_q   <= 1'b0;
      sel_dyn_q    <= 1'b0;
      latch_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      en_fin_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      stat_ack_q   <= grant && (grant_src == SRC_STAT);
      dyn_ack_q    <= grant && (grant_src == SRC_DYN);
      sel_stat_q   <= (state_d == ST_SHIFT) && (src_d == SRC_STAT);
      sel_dyn_q    <= (state_d == ST_SHIFT) && (src_d == SRC_DYN);
      latch_q      <= (state_d == ST_LATCH);
      done_q       <= done_d;
      busy_q       <= (state_d != ST_IDLE);
      if ((state_q == ST_LATCH) && (src_q == SRC_DYN)) en_fin_q <= 1'b1;
    end
  end

  sreg_piso #(
    .SIZESRSTAT (SIZESRSTAT),
    .CNT_W      (CNT_W)
  ) u_piso (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (grant),
    .shift_en (shift_en),
    .pdata    (pdata),
    .len      (len),
    .sdata    (bus.sdata),
    .last     (last)
  );

  assign bus.stat_ack = stat_ack_q;
  assign bus.dyn_ack  = dyn_ack_q;
  assign bus.sel_stat = sel_stat_q;
  assign bus.sel_dyn  = sel_dyn_q;
  assign bus.latch    = latch_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.en_fin   = en_fin_q;

endmodule

// File: tb/tb_sreg_load_sequencer.sv
// Directed + randomized bench for sreg_load_sequencer against a per-load waveform model.
module tb_sreg_load_sequencer;
  logic CLK;
  logic RST_N;

  sreg_load_sequencer_if #(.SIZESRSTAT(88), .SIZESRDYN(16)) bus ();

  sreg_load_sequencer #(
    .SIZESRSTAT   (88),
    .SIZESRDYN    (16),
    .SETUP_CYCLES (8),
    .HOLD_CYCLES  (4),
    .CNT_W        (7)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int acks_seen = 0;
  int latches_seen = 0;
  int grants_m = 0;
  int completes_m = 0;
  bit last_grant_m = 1'b1;
  bit en_fin_m = 1'b0;
  logic [87:0] stat_word;
  logic [15:0] dyn_word;

  // {stat_ack, dyn_ack, sel_stat, sel_dyn, sdata, latch, done, busy, en_fin}
  logic [8:0] obs;
  assign obs = {bus.stat_ack, bus.dyn_ack, bus.sel_stat, bus.sel_dyn, bus.sdata,
                bus.latch, bus.done, bus.busy, bus.en_fin};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pick(input bit s, input bit d);
    if (s && d) return ~last_grant_m;
    return d;
  endfunction

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      chk("idle", 32'(obs), 32'({8'b0, en_fin_m}));
    end
  endtask

  // Expects a grant on the next rising edge and follows the whole load cycle by cycle.
  task automatic expect_load(input bit is_dyn, input int raise_dyn_k, input int rst_k);
    int n;
    logic [87:0] w;
    bit sel;
    bit b;
    logic [8:0] e;
    n = is_dyn ? 16 : 88;
    w = is_dyn ? {dyn_word, 72'b0} : stat_word;
    grants_m++;
    last_grant_m = is_dyn;
    for (int k = 0; k <= n + 14; k++) begin
      @(negedge CLK);
      sel = (k >= 9) && (k < 9 + n);
      b   = sel ? w[87 - (k - 9)] : 1'b0;
      e   = {k == 0 && !is_dyn, k == 0 && is_dyn, sel && !is_dyn, sel && is_dyn, b,
             k == 9 + n, k == 14 + n, k < 14 + n, en_fin_m || (is_dyn && k >= 10 + n)};
      chk(is_dyn ? "dyn_load" : "stat_load", 32'(obs), 32'(e));
      if (k == 0) begin
        if (is_dyn) bus.dyn_req = 1'b0;
        else        bus.stat_req = 1'b0;
      end
      if (k == raise_dyn_k) bus.dyn_req = 1'b1;
      if (k == rst_k) begin
        RST_N = 1'b0;
        #1;
        chk("reset_abort", 32'(obs), 32'd0);
        en_fin_m = 1'b0;
        last_grant_m = 1'b1;
        return;
      end
    end
    if (is_dyn) en_fin_m = 1'b1;
    completes_m++;
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      total++;
      assert (!(bus.sel_stat && bus.sel_dyn)) else begin
        bad++;
        $error("FAIL sel_excl got=%b%b exp=not both", bus.sel_stat, bus.sel_dyn);
      end
      total++;
      assert (bus.sel_stat || bus.sel_dyn || !bus.sdata) else begin
        bad++;
        $error("FAIL sdata_idle got=%b exp=0", bus.sdata);
      end
      if (bus.stat_ack || bus.dyn_ack) acks_seen++;
      if (bus.latch) latches_seen++;
    end
  end

  initial begin
    bit s, d, w1;
    RST_N = 1'b0;
    bus.stat_req = 1'b0;
    bus.dyn_req  = 1'b0;
    bus.stat_data = '0;
    bus.dyn_data  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("in_reset", 32'(obs), 32'd0);
    end
    RST_N = 1'b1;
    idle_check(3);

    // static only, 88'h80..01
    stat_word = '0;
    stat_word[87] = 1'b1;
    stat_word[0]  = 1'b1;
    bus.stat_data = stat_word;
    bus.stat_req = 1'b1;
    expect_load(1'b0, -1, -1);
    idle_check(2);

    // dynamic only, 16'h8001
    dyn_word = 16'h8001;
    bus.dyn_data = dyn_word;
    bus.dyn_req = 1'b1;
    expect_load(1'b1, -1, -1);
    idle_check(2);

    // simultaneous requests, then both again: round-robin alternates
    for (int r = 0; r < 2; r++) begin
      stat_word = {$urandom, $urandom, 24'($urandom)};
      dyn_word  = 16'($urandom);
      bus.stat_data = stat_word;
      bus.dyn_data  = dyn_word;
      bus.stat_req = 1'b1;
      bus.dyn_req  = 1'b1;
      w1 = pick(1'b1, 1'b1);
      chk("rr_first_is_stat", 32'(w1), 32'd0);
      expect_load(w1, -1, -1);
      expect_load(~w1, -1, -1);
    end

    // dyn request raised mid static shift stays pending until static done
    stat_word = {$urandom, $urandom, 24'($urandom)};
    dyn_word  = 16'($urandom);
    bus.stat_data = stat_word;
    bus.dyn_data  = dyn_word;
    bus.stat_req = 1'b1;
    expect_load(1'b0, 40, -1);
    expect_load(1'b1, -1, -1);

    // reset while dynamic bit 7 is on sdata
    dyn_word = 16'($urandom);
    bus.dyn_data = dyn_word;
    bus.dyn_req = 1'b1;
    expect_load(1'b1, -1, 17);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("held_reset", 32'(obs), 32'd0);
    end
    RST_N = 1'b1;
    idle_check(3);

    // after reset static wins a tie again; then random traffic
    stat_word = {$urandom, $urandom, 24'($urandom)};
    dyn_word  = 16'($urandom);
    bus.stat_data = stat_word;
    bus.dyn_data  = dyn_word;
    bus.stat_req = 1'b1;
    bus.dyn_req  = 1'b1;
    w1 = pick(1'b1, 1'b1);
    expect_load(w1, -1, -1);
    expect_load(~w1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      s = 1'($urandom);
      d = 1'($urandom);
      if (!s && !d) d = 1'b1;
      stat_word = {$urandom, $urandom, 24'($urandom)};
      dyn_word  = 16'($urandom);
      bus.stat_data = stat_word;
      bus.dyn_data  = dyn_word;
      bus.stat_req = s;
      bus.dyn_req  = d;
      w1 = pick(s, d);
      expect_load(w1, -1, -1);
      if (s && d) expect_load(~w1, -1, -1);
      idle_check(int'($urandom_range(0, 3)));
    end

    idle_check(2);
    chk("ack_count", 32'(acks_seen), 32'(grants_m));
    chk("latch_count", 32'(latches_seen), 32'(completes_m));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
